// File: rtl/imem_prefetch_buf_pkg.sv
// imem_prefetch_buf_pkg: shared widths, depth default and fetch/prefetch bus types
package imem_prefetch_buf_pkg;
  localparam int XLEN = 32;
  localparam int PF_DEPTH = 4;
  typedef struct packed {
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            ready;
  } type_if2pf_s;
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } type_pf2if_s;
endpackage

// File: rtl/imem_prefetch_buf_pf_fifo.sv
// pf_fifo: synchronous in-order FIFO with flush and occupancy count
module pf_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  // Pointers wrap naturally because DEPTH is a power of two; flush empties everything
  always_comb begin
    wr_d = flush ? '0 : wr_q + AW'(push);
    rd_d = flush ? '0 : rd_q + AW'(pop);
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  // Storage needs no reset; the head is only observed while count is nonzero
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata;
  end
  assign rdata = mem_q[rd_q];
  assign count = count_q;
endmodule

// File: rtl/imem_prefetch_buf.sv
// imem_prefetch_buf: sequential instruction prefetch with credit flow control; PCORE_PREFETCH_BYPASS_EN presents an empty-FIFO return combinationally
module imem_prefetch_buf import imem_prefetch_buf_pkg::*; #(
  parameter int DEPTH = PF_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            fetch2pf_ready_i,
  output logic            pf2fetch_valid_o,
  output logic [XLEN-1:0] pf2fetch_instr_o,
  output logic [XLEN-1:0] pf2fetch_pc_o,
  output logic            if2imem_req_o,
  output logic [XLEN-1:0] if2imem_addr_o,
  input  logic [XLEN-1:0] imem2if_rdata_i
);
  localparam int CW = $clog2(DEPTH + 1);
  type_if2pf_s in_s;
  type_pf2if_s out_s;
  logic [XLEN-1:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d;
  logic inflight_q, inflight_d;
  logic [CW-1:0] count;
  logic [2*XLEN-1:0] head;
  logic push, pop, fifo_pop, byp, req;
  logic [CW:0] credit;
  assign in_s = '{redirect: redirect_i, redirect_pc: redirect_pc_i, ready: fetch2pf_ready_i};
  // Present FIFO head (zero when empty), push returns, and issue only while credit remains
  always_comb begin
`ifdef PCORE_PREFETCH_BYPASS_EN
    byp = count == '0 && inflight_q && !in_s.redirect;
`else
    byp = 1'b0;
`endif
    out_s.valid = count != '0 || byp;
    out_s.instr = byp ? imem2if_rdata_i : (count != '0 ? head[2*XLEN-1:XLEN] : '0);
    out_s.pc = byp ? inflight_pc_q : (count != '0 ? head[XLEN-1:0] : '0);
    pop = out_s.valid && in_s.ready;
    push = inflight_q && !in_s.redirect && !(byp && in_s.ready);
    fifo_pop = pop && !in_s.redirect && !byp;
    credit = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    req = !rst_n && !in_s.redirect && credit < (CW+1)'(DEPTH);
  end
  // Next fetch PC: redirect wins and is word-aligned, otherwise advance on issue
  always_comb begin
    pc_d = in_s.redirect ? (in_s.redirect_pc & ~XLEN'(3)) : (req ? pc_q + XLEN'(4) : pc_q);
    inflight_d = req;
    inflight_pc_d = req ? pc_q : inflight_pc_q;
  end
  // Fetch PC and in-flight request tracking
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q <= pc_d;
      inflight_q <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end
  pf_fifo #(.DEPTH(DEPTH), .W(2*XLEN)) u_fifo (
    .clk(clk),
    .rst(rst_n),
    .flush(in_s.redirect),
    .push(push),
    .pop(fifo_pop),
    .wdata({imem2if_rdata_i, inflight_pc_q}),
    .rdata(head),
    .count(count)
  );
  assign pf2fetch_valid_o = out_s.valid;
  assign pf2fetch_instr_o = out_s.instr;
  assign pf2fetch_pc_o = out_s.pc;
  assign if2imem_req_o = req;
  assign if2imem_addr_o = pc_q;
endmodule

// File: tb/tb_imem_prefetch_buf.sv
// tb_imem_prefetch_buf: directed checks of fetch order, backpressure, redirect, wrap and async reset
module tb_imem_prefetch_buf;
  localparam logic [31:0] M = 32'hA5A5_0000;
  logic clk = 1'b0;
  logic rst_n, redirect, ready, valid, req;
  logic [31:0] redirect_pc, instr, pc, addr;
  logic [31:0] rdata = 32'hDEAD_BEEF;
  int checks = 0;
  int fails = 0;

  imem_prefetch_buf #(.DEPTH(4), .RESET_PC(32'h80)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .fetch2pf_ready_i(ready), .pf2fetch_valid_o(valid), .pf2fetch_instr_o(instr),
    .pf2fetch_pc_o(pc), .if2imem_req_o(req), .if2imem_addr_o(addr), .imem2if_rdata_i(rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (req) rdata <= addr ^ M;

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    cyc; cyc; #1;
    checks++;
    if ({valid, req} !== 2'b00) begin fails++; $display("FAIL reset_valid_req got %b exp 00", {valid, req}); end
    checks++;
    if ({instr, pc} !== 64'h0) begin fails++; $display("FAIL reset_data got %h exp 0", {instr, pc}); end
  endtask

  task automatic test_sequential;
    logic [31:0] e;
    rst_n = 1'b0; ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      e = 32'h80 + 32'(4*k);
      checks++;
      if ({req, addr} !== {1'b1, e}) begin fails++; $display("FAIL seq_req k=%0d got %b/%h exp 1/%h", k, req, addr, e); end
      e = 32'h80 + 32'(4*(k-2));
      checks++;
      if (k < 2) begin
        if (valid !== 1'b0) begin fails++; $display("FAIL seq_early_valid k=%0d got %b exp 0", k, valid); end
      end else if ({valid, pc, instr} !== {1'b1, e, e ^ M}) begin
        fails++; $display("FAIL seq_word k=%0d got %b/%h/%h exp 1/%h/%h", k, valid, pc, instr, e, e ^ M);
      end
      cyc;
    end
  endtask

  task automatic test_backpressure;
    int nreq;
    logic [31:0] e;
    ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
    #1;
    checks++;
    if (req !== 1'b0) begin fails++; $display("FAIL bp_redirect_req got %b exp 0", req); end
    cyc;
    redirect = 1'b0;
    nreq = 0;
    for (int n = 0; n < 10; n++) begin
      #1;
      if (req) begin
        e = 32'h200 + 32'(4*nreq);
        checks++;
        if (addr !== e) begin fails++; $display("FAIL bp_addr n=%0d got %h exp %h", n, addr, e); end
        nreq++;
      end
      cyc;
    end
    checks++;
    if (nreq !== 4) begin fails++; $display("FAIL bp_req_count got %0d exp 4", nreq); end
    #1;
    checks++;
    if ({valid, pc, req} !== {1'b1, 32'h200, 1'b0}) begin fails++; $display("FAIL bp_stalled got %b/%h/%b exp 1/200/0", valid, pc, req); end
    ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      #1;
      e = 32'h200 + 32'(4*j);
      checks++;
      if ({valid, pc, instr} !== {1'b1, e, e ^ M}) begin fails++; $display("FAIL bp_drain j=%0d got %b/%h/%h exp 1/%h/%h", j, valid, pc, instr, e, e ^ M); end
      e = 32'h210 + 32'(4*j);
      checks++;
      if ({req, addr} !== {1'b1, e}) begin fails++; $display("FAIL bp_resume j=%0d got %b/%h exp 1/%h", j, req, addr, e); end
      cyc;
    end
  endtask

  task automatic test_redirect_inflight;
    logic [31:0] e;
    #1;
    checks++;
    if ({valid, pc} !== {1'b1, 32'h220}) begin fails++; $display("FAIL rdi_pre got %b/%h exp 1/220", valid, pc); end
    ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h1002;
    #1;
    checks++;
    if (req !== 1'b0) begin fails++; $display("FAIL rdi_req got %b exp 0", req); end
    cyc;
    redirect = 1'b0; ready = 1'b1;
    #1;
    checks++;
    if ({valid, req, addr} !== {1'b0, 1'b1, 32'h1000}) begin fails++; $display("FAIL rdi_r1 got %b/%b/%h exp 0/1/1000", valid, req, addr); end
    cyc; #1;
    checks++;
    if ({valid, addr} !== {1'b0, 32'h1004}) begin fails++; $display("FAIL rdi_r2 got %b/%h exp 0/1004", valid, addr); end
    cyc;
    for (int i = 0; i < 3; i++) begin
      #1;
      e = 32'h1000 + 32'(4*i);
      checks++;
      if ({valid, pc, instr} !== {1'b1, e, e ^ M}) begin fails++; $display("FAIL rdi_word i=%0d got %b/%h/%h exp 1/%h/%h", i, valid, pc, instr, e, e ^ M); end
      cyc;
    end
  endtask

  task automatic test_redirect_pop;
    logic [31:0] e;
    ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h3000;
    #1;
    checks++;
    if ({valid, pc, req} !== {1'b1, 32'h100C, 1'b0}) begin fails++; $display("FAIL rdp_cycle got %b/%h/%b exp 1/100c/0", valid, pc, req); end
    cyc;
    redirect = 1'b0;
    for (int n = 0; n < 6; n++) begin
      #1;
      e = 32'h3000 + 32'(4*(n-2));
      checks++;
      if (n < 2) begin
        if (valid !== 1'b0) begin fails++; $display("FAIL rdp_flushed n=%0d got %b/%h exp 0", n, valid, pc); end
      end else if ({valid, pc, instr} !== {1'b1, e, e ^ M}) begin
        fails++; $display("FAIL rdp_word n=%0d got %b/%h/%h exp 1/%h/%h", n, valid, pc, instr, e, e ^ M);
      end
      cyc;
    end
  endtask

  task automatic test_pc_wrap;
    logic [31:0] e;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    #1;
    cyc;
    redirect = 1'b0;
    for (int n = 0; n < 6; n++) begin
      #1;
      e = 32'hFFFF_FFF8 + 32'(4*n);
      checks++;
      if ({req, addr} !== {1'b1, e}) begin fails++; $display("FAIL wrap_addr n=%0d got %b/%h exp 1/%h", n, req, addr, e); end
      if (n >= 2) begin
        e = 32'hFFFF_FFF8 + 32'(4*(n-2));
        checks++;
        if ({valid, pc, instr} !== {1'b1, e, e ^ M}) begin fails++; $display("FAIL wrap_word n=%0d got %b/%h/%h exp 1/%h/%h", n, valid, pc, instr, e, e ^ M); end
      end
      cyc;
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] e;
    ready = 1'b0;
    #1;
    cyc; #1;
    checks++;
    if ({valid, pc} !== {1'b1, 32'h8}) begin fails++; $display("FAIL ar_pre got %b/%h exp 1/8", valid, pc); end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({valid, req} !== 2'b00) begin fails++; $display("FAIL ar_drop_ctl got %b exp 00", {valid, req}); end
    checks++;
    if ({instr, pc} !== 64'h0) begin fails++; $display("FAIL ar_drop_data got %h exp 0", {instr, pc}); end
    cyc; #1;
    checks++;
    if ({valid, req} !== 2'b00) begin fails++; $display("FAIL ar_hold got %b exp 00", {valid, req}); end
    rst_n = 1'b0; ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      e = 32'h80 + 32'(4*k);
      checks++;
      if ({req, addr} !== {1'b1, e}) begin fails++; $display("FAIL ar_req k=%0d got %b/%h exp 1/%h", k, req, addr, e); end
      e = 32'h80 + 32'(4*(k-2));
      checks++;
      if (k < 2) begin
        if (valid !== 1'b0) begin fails++; $display("FAIL ar_stale k=%0d got %b/%h exp 0", k, valid, pc); end
      end else if ({valid, pc, instr} !== {1'b1, e, e ^ M}) begin
        fails++; $display("FAIL ar_word k=%0d got %b/%h/%h exp 1/%h/%h", k, valid, pc, instr, e, e ^ M);
      end
      cyc;
    end
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_backpressure;
    test_redirect_inflight;
    test_redirect_pop;
    test_pc_wrap;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
